// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard frame receiver and make/break decoder producing held key levels.
// Optional `define PS2_WASD_ALIAS_EN makes A/D/W alias Left/Right/Jump.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYCLES = 65000,
    parameter int TIMEOUT_WIDTH  = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_db,
    input  logic       ps2_data_db,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       key_left,
    output logic       key_right,
    output logic       key_jump
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

`ifdef PS2_WASD_ALIAS_EN
    localparam int NKEYS = 6;
`else
    localparam int NKEYS = 3;
`endif

    state_t                   state_q, state_d;
    logic                     prev_clk_q;
    logic                     fall;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic                     par_q, par_d;
    logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;
    logic                     timeout;
    logic                     accept, err;
    logic [7:0]               code_q, code_d;
    logic                     code_valid_q, code_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic                     ext_q, ext_d;
    logic                     brk_q, brk_d;
    // [0]=left arrow, [1]=right arrow, [2]=space; alias build adds [3]=A, [4]=D, [5]=W
    logic [NKEYS-1:0]         keys_q, keys_d;

    assign fall    = prev_clk_q & ~ps2_clk_db;
    assign timeout = (state_q != S_IDLE) && !fall && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        accept    = 1'b0;
        err       = 1'b0;
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!ps2_data_db) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {ps2_data_db, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = ps2_data_db;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (ps2_data_db && ^{shift_q, par_q}) accept = 1'b1;
                    else err = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            state_d = S_IDLE;
            shift_d = 8'h00;
            err     = 1'b1;
        end
    end

    always_comb begin
        if (fall || timeout || state_q == S_IDLE) to_cnt_d = '0;
        else to_cnt_d = to_cnt_q + 1'b1;
    end

    // Byte decode: prefixes only set flags, any other byte consumes them.
    always_comb begin
        code_valid_d = accept;
        frame_err_d  = err;
        code_d       = code_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        keys_d       = keys_q;
        if (accept) begin
            code_d = shift_q;
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q && shift_q == 8'h6B) keys_d[0] = ~brk_q;
                if (ext_q && shift_q == 8'h74) keys_d[1] = ~brk_q;
                if (!ext_q && shift_q == 8'h29) keys_d[2] = ~brk_q;
`ifdef PS2_WASD_ALIAS_EN
                if (!ext_q && shift_q == 8'h1C) keys_d[3] = ~brk_q;
                if (!ext_q && shift_q == 8'h23) keys_d[4] = ~brk_q;
                if (!ext_q && shift_q == 8'h1D) keys_d[5] = ~brk_q;
`endif
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prev_clk_q   <= 1'b1;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            keys_q       <= '0;
        end else begin
            state_q      <= state_d;
            prev_clk_q   <= ps2_clk_db;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            keys_q       <= keys_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
`ifdef PS2_WASD_ALIAS_EN
    assign key_left   = keys_q[0] | keys_q[3];
    assign key_right  = keys_q[1] | keys_q[4];
    assign key_jump   = keys_q[2] | keys_q[5];
`else
    assign key_left   = keys_q[0];
    assign key_right  = keys_q[1];
    assign key_jump   = keys_q[2];
`endif

endmodule
